// File: rtl/cbus_pkg.sv
// Shared bus request/response types for the CPU-side bus.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Two-port arbiter: instruction (port 0) and data (port 1) masters share one
// downstream bus. One owner is granted per transaction and held until the
// ready&last beat or until the owner drops valid.
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireq0,
    output cbus_resp_t iresp0,
    input  cbus_req_t  ireq1,
    output cbus_resp_t iresp1,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic [1:0] grant
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e    state_q, state_d;
    logic      sel_q, sel_d;
    logic      last_q, last_d;
    cbus_req_t owner_req;
    logic      complete;

    // Request of the current owner; only meaningful in StBusy.
    always_comb begin
        owner_req = sel_q ? ireq1 : ireq0;
    end

    assign complete = (state_q == StBusy) && oresp.ready && oresp.last;

    // State, owner and last-served registers; reset makes port 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate only in StIdle, release on completion or abort.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (ireq0.valid || ireq1.valid) begin
                    state_d = StBusy;
                    if (ireq0.valid && ireq1.valid) begin
                        sel_d = RR_EN ? ~last_q : 1'b1;
                    end else begin
                        sel_d = ireq1.valid;
                    end
                end
            end
            StBusy: begin
                if (complete) begin
                    state_d = StIdle;
                    last_d  = sel_q;
                end else if (!owner_req.valid) begin
                    // Abort: owner gave up, history is left untouched.
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: forward only the owner while busy; everything else is zero.
    always_comb begin
        oreq   = '0;
        iresp0 = '0;
        iresp1 = '0;
        grant  = 2'b00;
        if (state_q == StBusy) begin
            grant = sel_q ? 2'b10 : 2'b01;
            if (owner_req.valid) begin
                oreq = owner_req;
            end
            if (sel_q) begin
                iresp1 = oresp;
            end else begin
                iresp0 = oresp;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: a per-cycle vector table checked via a
// scoreboard queue, plus hand sequences for async reset and fixed priority.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       clk;
    logic       reset;
    cbus_req_t  ireq0, ireq1;
    cbus_resp_t oresp;
    cbus_resp_t rr_iresp0, rr_iresp1, fp_iresp0, fp_iresp1;
    cbus_req_t  rr_oreq, fp_oreq;
    logic [1:0] rr_grant, fp_grant;

    cbus_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk    (clk),
        .reset  (reset),
        .ireq0  (ireq0),
        .iresp0 (rr_iresp0),
        .ireq1  (ireq1),
        .iresp1 (rr_iresp1),
        .oreq   (rr_oreq),
        .oresp  (oresp),
        .grant  (rr_grant)
    );

    cbus_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk    (clk),
        .reset  (reset),
        .ireq0  (ireq0),
        .iresp0 (fp_iresp0),
        .ireq1  (ireq1),
        .iresp1 (fp_iresp1),
        .oreq   (fp_oreq),
        .oresp  (oresp),
        .grant  (fp_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic       v1;
        logic       rdy;
        logic       lst;
        logic [1:0] g;
        logic       ov;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] grant;
        cbus_req_t  oreq;
        cbus_resp_t iresp0;
        cbus_resp_t iresp1;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cbus_req_t mk_req(input logic port, input logic v);
        cbus_req_t r;
        if (!port) begin
            r = '{valid: v, is_write: 1'b0, addr: 32'h0000_4000, size: 3'd2,
                  strobe: 4'hf, len: 4'd3, burst: 2'd1, data: 32'h1111_1111};
        end else begin
            r = '{valid: v, is_write: 1'b1, addr: 32'h8000_1000, size: 3'd2,
                  strobe: 4'hc, len: 4'd0, burst: 2'd0, data: 32'hA5A5_5A5A};
        end
        return r;
    endfunction

    // Scoreboard monitor: compares the expectation pushed for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("row%0d grant", e.idx), 128'(rr_grant), 128'(e.grant));
            check($sformatf("row%0d oreq", e.idx), 128'(rr_oreq), 128'(e.oreq));
            check($sformatf("row%0d iresp0", e.idx), 128'(rr_iresp0), 128'(e.iresp0));
            check($sformatf("row%0d iresp1", e.idx), 128'(rr_iresp1), 128'(e.iresp1));
        end
    end

    initial begin
        vec_t vecs[$];
        exp_t e;
        int   guard;

        // v0, v1, rdy, lst, expected grant, expected oreq.valid
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}); // idle after reset
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}); // port 1 alone: arbitrate
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1}); // single-beat done
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0}); // RR tie, last=1
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}); // 4-beat burst on port 0
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1}); // beat 1
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1}); // beat 2, port 1 joins
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1}); // beat 3
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1}); // beat 4, last
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}); // mandatory idle
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}); // abort sequence
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0}); // owner drops valid
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}); // tie: last still 1
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0});

        // Reset with both ports requesting: all outputs zero.
        reset = 1'b1;
        ireq0 = mk_req(1'b0, 1'b1);
        ireq1 = mk_req(1'b1, 1'b1);
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'hDEAD_BEEF};
        #12;
        check("reset grant", 128'(rr_grant), 128'(2'b00));
        check("reset oreq", 128'(rr_oreq), 128'(0));
        check("reset iresp0", 128'(rr_iresp0), 128'(0));
        check("reset iresp1", 128'(rr_iresp1), 128'(0));
        check("reset fp grant", 128'(fp_grant), 128'(2'b00));
        ireq0 = mk_req(1'b0, 1'b0);
        ireq1 = mk_req(1'b1, 1'b0);
        oresp = '0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            ireq0 = mk_req(1'b0, vecs[i].v0);
            ireq1 = mk_req(1'b1, vecs[i].v1);
            oresp = '{ready: vecs[i].rdy, last: vecs[i].lst, data: 32'hD00D_0000 | 32'(i)};
            e.idx    = i;
            e.grant  = vecs[i].g;
            e.oreq   = !vecs[i].ov ? '0 : (vecs[i].g == 2'b10 ? ireq1 : ireq0);
            e.iresp0 = vecs[i].g[0] ? oresp : '0;
            e.iresp1 = vecs[i].g[1] ? oresp : '0;
            sb.push_back(e);
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard drained", 128'(sb.size()), 128'(0));

        // Async reset in the middle of a busy cycle.
        @(posedge clk);
        #1;
        ireq0 = mk_req(1'b0, 1'b1);
        ireq1 = mk_req(1'b1, 1'b0);
        oresp = '{ready: 1'b0, last: 1'b0, data: 32'h1234_5678};
        @(posedge clk);
        @(negedge clk);
        check("pre-reset busy grant", 128'(rr_grant), 128'(2'b01));
        #2;
        reset = 1'b1;
        #1;
        check("async reset grant", 128'(rr_grant), 128'(2'b00));
        check("async reset oreq", 128'(rr_oreq), 128'(0));
        check("async reset iresp0", 128'(rr_iresp0), 128'(0));
        @(posedge clk);
        #2;
        ireq1 = mk_req(1'b1, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset idle grant", 128'(rr_grant), 128'(2'b00));
        @(posedge clk);
        #1;
        check("post-reset tie grant", 128'(rr_grant), 128'(2'b01));
        check("post-reset oreq", 128'(rr_oreq), 128'(ireq0));

        // Fixed priority: port 1 wins every tie, port 0 only after port 1 leaves.
        #2;
        reset = 1'b1;
        ireq0 = mk_req(1'b0, 1'b1);
        ireq1 = mk_req(1'b1, 1'b1);
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'hCAFE_0001};
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fp grant %0d", i), 128'(fp_grant), 128'((i % 2 == 0) ? 2'b10 : 2'b00));
            if (i == 0) begin
                check("fp oreq port1", 128'(fp_oreq), 128'(ireq1));
                check("fp iresp1", 128'(fp_iresp1), 128'(oresp));
                check("fp iresp0 starved", 128'(fp_iresp0), 128'(0));
            end
        end
        ireq1 = mk_req(1'b1, 1'b0);
        @(negedge clk);
        check("fp idle before port0", 128'(fp_grant), 128'(2'b00));
        @(negedge clk);
        check("fp port0 grant", 128'(fp_grant), 128'(2'b01));
        check("fp oreq port0", 128'(fp_oreq), 128'(ireq0));
        check("fp iresp0", 128'(fp_iresp0), 128'(oresp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
